// File: rtl/trax_uart_pkg.sv
// Shared definitions for the Trax order-path serial front end:
// receiver state encoding, default bit timing and ASCII symbols.
package trax_uart_pkg;

  // Default bit period: 50 MHz system clock at 115200 baud
  localparam int CLKS_PER_BIT_DEF = 434;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

  // ASCII symbols exchanged on the order path
  localparam logic [7:0] ASCII_DASH   = 8'd45;  // '-'
  localparam logic [7:0] ASCII_W      = 8'd87;  // 'W'
  localparam logic [7:0] ASCII_B      = 8'd66;  // 'B'
  localparam logic [7:0] ASCII_LF     = 8'd10;  // line feed
  localparam logic [7:0] ASCII_PLUS   = 8'd43;  // '+'
  localparam logic [7:0] ASCII_SLASH  = 8'd47;  // '/'
  localparam logic [7:0] ASCII_BSLASH = 8'd92;  // '\'

  // Shift one received bit into the MSB of an LSB-first shift register
  function automatic logic [7:0] shift_in_lsb_first(input logic [7:0] sh,
                                                    input logic       bit_in);
    return {bit_in, sh[7:1]};
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop bit synchronizer for an asynchronous input. Both flops
// reset to RST_VAL so the output shows a chosen quiet level while
// reset is held.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops to settle metastability on i_d
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver. Each framed byte is delivered on outData with
// a one-cycle dataReady strobe; a low stop bit raises a one-cycle
// frameErr instead and parks the receiver until the line goes idle.
module uart_byte_rx
  import trax_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] outData,
  output logic       dataReady,
  output logic       frameErr,
  output logic       busy
);

  localparam int              CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] L_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] L_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             w_rx_s;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  sync2 #(
    .RST_VAL (1'b1)
  ) u_sync2 (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  // Receiver FSM: start validation at mid start bit, mid-bit data sampling,
  // stop-bit check, and registered strobes/busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      outData   <= 8'd0;
      dataReady <= 1'b0;
      frameErr  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      dataReady <= 1'b0;
      frameErr  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_rx_s == 1'b0) begin
            r_state <= ST_START;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end

        ST_START: begin
          if (r_cnt == L_HALF) begin
            r_cnt <= '0;
            if (w_rx_s == 1'b0) begin
              r_state   <= ST_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              // Start bit vanished before mid-bit: treat as a line glitch
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (r_cnt == L_FULL) begin
            r_cnt   <= '0;
            r_shift <= shift_in_lsb_first(r_shift, w_rx_s);
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (r_cnt == L_FULL) begin
            r_cnt <= '0;
            if (w_rx_s == 1'b1) begin
              // Leave at mid stop bit so a following start edge is not missed
              outData   <= r_shift;
              dataReady <= 1'b1;
              r_state   <= ST_IDLE;
              busy      <= 1'b0;
            end else begin
              frameErr <= 1'b1;
              r_state  <= ST_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_WAIT_IDLE: begin
          // A held-low line (break) must not look like a stream of new frames
          r_cnt <= '0;
          if (w_rx_s == 1'b1) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_state <= ST_WAIT_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
